// File: rtl/quadratura_decoder_pkg.sv
// quadratura_pkg: shared quadrature state constants and helpers.
package quadratura_pkg;
  localparam logic [1:0] Q_00 = 2'b00;
  localparam logic [1:0] Q_01 = 2'b01;
  localparam logic [1:0] Q_11 = 2'b11;
  localparam logic [1:0] Q_10 = 2'b10;
  function automatic logic [1:0] prox_frente(input logic [1:0] s);
    return s == Q_00 ? Q_01 : s == Q_01 ? Q_11 : s == Q_11 ? Q_10 : Q_00;
  endfunction
  function automatic int largura_cnt(input int f);
    return $clog2(f + 1);
  endfunction
endpackage

// File: rtl/quadratura_decoder_if.sv
// quadratura_decoder_if: encoder pins, control and pulse outputs of the decoder.
// master drives canal_a/canal_b/habilitar/limpar_erro; slave drives acrescer/decrecer/erro/estado_ab.
interface quadratura_decoder_if;
  logic       canal_a;
  logic       canal_b;
  logic       habilitar;
  logic       limpar_erro;
  logic       acrescer;
  logic       decrecer;
  logic       erro;
  logic [1:0] estado_ab;
  modport master (output canal_a, canal_b, habilitar, limpar_erro, input acrescer, decrecer, erro, estado_ab);
  modport slave (input canal_a, canal_b, habilitar, limpar_erro, output acrescer, decrecer, erro, estado_ab);
endinterface

// File: rtl/quadratura_decoder_filtro_glitch.sv
// filtro_glitch: per-channel synchronizer plus persistence filter.
// Ports: clk, rst (async, active-high), i_init (load synced directly), i_raw (async pin), o_filt (filtered level).
module filtro_glitch
  import quadratura_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTRO_CICLOS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_init,
  input  logic i_raw,
  output logic o_filt
);
  localparam int W = largura_cnt(FILTRO_CICLOS);
  localparam logic [W-1:0] LIM = W'(FILTRO_CICLOS - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [W-1:0]           r_cnt;
  logic                   r_filt;
  logic                   w_synced;
  logic                   w_diff;
  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_diff   = w_synced != r_filt;
  assign o_filt   = r_filt;
  // The update fires on the edge where the count would reach FILTRO_CICLOS,
  // so a level lasting exactly FILTRO_CICLOS synced cycles is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (i_init || (w_diff && r_cnt == LIM)) begin
        r_filt <= w_synced;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= w_diff ? r_cnt + 1'b1 : '0;
      end
    end
  end
endmodule

// File: rtl/quadratura_decoder.sv
// quadratura_decoder: synchronize, deglitch and decode A/B into acrescer/decrecer pulses.
// Ports: clk, rst (async, active-high), bus (quadratura_decoder_if.slave).
// Macro QUADRATURA_X4_EN: defined = x4 decoding, undefined = x1 (10->00 up, 01->00 down).
module quadratura_decoder
  import quadratura_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTRO_CICLOS = 4
) (
  input logic clk,
  input logic rst,
  quadratura_decoder_if.slave bus
);
  localparam int IW = $clog2(SYNC_STAGES + 3);
  localparam logic [IW-1:0] I_LOAD = IW'(SYNC_STAGES + 1);
  localparam logic [IW-1:0] I_RUN  = IW'(SYNC_STAGES + 2);
  logic [IW-1:0] r_init;
  logic [1:0]    r_prev;
  logic          r_acr;
  logic          r_dec;
  logic          r_erro;
  logic          w_fa;
  logic          w_fb;
  logic [1:0]    w_cur;
  logic          w_load;
  logic          w_en;
  logic          w_ilg;
  logic          w_up;
  logic          w_dn;
  filtro_glitch #(.SYNC_STAGES(SYNC_STAGES), .FILTRO_CICLOS(FILTRO_CICLOS)) u_fa (
    .clk(clk), .rst(rst), .i_init(w_load), .i_raw(bus.canal_a), .o_filt(w_fa)
  );
  filtro_glitch #(.SYNC_STAGES(SYNC_STAGES), .FILTRO_CICLOS(FILTRO_CICLOS)) u_fb (
    .clk(clk), .rst(rst), .i_init(w_load), .i_raw(bus.canal_b), .o_filt(w_fb)
  );
  assign w_cur  = {w_fa, w_fb};
  assign w_load = r_init < I_LOAD;
  // Decoding waits one extra cycle after loading so r_prev already holds the loaded state.
  assign w_en   = r_init == I_RUN && bus.habilitar;
  assign w_ilg  = &(r_prev ^ w_cur);
`ifdef QUADRATURA_X4_EN
  assign w_up   = prox_frente(r_prev) == w_cur;
  assign w_dn   = prox_frente(w_cur) == r_prev;
`else
  assign w_up   = r_prev == Q_10 && w_cur == Q_00;
  assign w_dn   = r_prev == Q_01 && w_cur == Q_00;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init <= '0;
      r_prev <= Q_00;
      r_acr  <= 1'b0;
      r_dec  <= 1'b0;
      r_erro <= 1'b0;
    end else begin
      r_init <= r_init == I_RUN ? r_init : r_init + 1'b1;
      r_prev <= w_cur;
      r_acr  <= w_en && w_up;
      r_dec  <= w_en && w_dn;
      r_erro <= (w_en && w_ilg) || (r_erro && !bus.limpar_erro);
    end
  end
  assign bus.acrescer  = r_acr;
  assign bus.decrecer  = r_dec;
  assign bus.erro      = r_erro;
  assign bus.estado_ab = w_cur;
endmodule

// File: tb/tb_quadratura_decoder.sv
// tb_quadratura_decoder: directed test-plan sequences plus random stimulus against a windowed behavioural model.
module tb_quadratura_decoder;
  localparam int S = 2;
  localparam int F = 4;
`ifdef QUADRATURA_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  quadratura_decoder_if bus();
  quadratura_decoder #(.SYNC_STAGES(S), .FILTRO_CICLOS(F)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n = 0;
  bit [1:0] rab[$];
  bit [1:0] fh[$];
  bit m_acr = 0, m_dec = 0, m_err = 0;
  int n_acr = 0, n_dec = 0, last_acr = 0, last_dec = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int pos(input bit [1:0] v);
    return v == 2'b00 ? 0 : v == 2'b01 ? 1 : v == 2'b11 ? 2 : 3;
  endfunction
  // Synced value seen by the filter at edge k: the pin as sampled S edges earlier.
  function automatic bit syn(input int k, input int ch);
    if (k - S < 1) return 1'b0;
    return rab[k-S-1][ch];
  endfunction
  // Model: filtered level changes once F consecutive synced samples agree on a new value;
  // steps are classified by distance along the Gray cycle 00,01,11,10.
  initial begin
    bit [1:0] cur, prv, nf;
    int d;
    bit en, same;
    fh.push_back(2'b00);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        n = 0;
        rab.delete();
        fh.delete();
        fh.push_back(2'b00);
        m_acr = 0; m_dec = 0; m_err = 0;
      end else begin
        n++;
        rab.push_back({bus.canal_a, bus.canal_b});
        cur = fh[n-1];
        prv = n >= 2 ? fh[n-2] : 2'b00;
        nf = cur;
        for (int ch = 0; ch < 2; ch++) begin
          if (n <= S + 1) nf[ch] = syn(n, ch);
          else begin
            same = 1;
            for (int j = 1; j < F; j++) if (syn(n - j, ch) != syn(n, ch)) same = 0;
            if (same && syn(n, ch) != cur[ch]) nf[ch] = syn(n, ch);
          end
        end
        fh.push_back(nf);
        d = (pos(cur) - pos(prv) + 4) % 4;
        en = n >= S + 3 && bus.habilitar;
        m_acr = en && d == 1 && (X4 || cur == 2'b00);
        m_dec = en && d == 3 && (X4 || cur == 2'b00);
        m_err = (en && d == 2) || (m_err && !bus.limpar_erro);
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      chk("acrescer", int'(bus.acrescer), rst ? 0 : int'(m_acr));
      chk("decrecer", int'(bus.decrecer), rst ? 0 : int'(m_dec));
      chk("erro", int'(bus.erro), rst ? 0 : int'(m_err));
      chk("estado_ab", int'(bus.estado_ab), rst ? 0 : int'(fh[n]));
      if (!rst && bus.acrescer) begin n_acr++; last_acr = cyc; end
      if (!rst && bus.decrecer) begin n_dec++; last_dec = cyc; end
    end
  end
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic put(input bit [1:0] v, input int hold, output int e);
    {bus.canal_a, bus.canal_b} = v;
    e = cyc;
    tick(hold);
  endtask
  initial begin
    int e, a0, d0;
    {bus.canal_a, bus.canal_b} = 2'b00;
    bus.habilitar = 1'b1;
    bus.limpar_erro = 1'b0;
    tick(3);
    chk("reset_acr", int'(bus.acrescer), 0);
    chk("reset_dec", int'(bus.decrecer), 0);
    chk("reset_erro", int'(bus.erro), 0);
    chk("reset_estado", int'(bus.estado_ab), 0);
    rst = 1'b0;
    tick(10);
    a0 = n_acr; d0 = n_dec;
    put(2'b01, 10, e); put(2'b11, 10, e); put(2'b10, 10, e); put(2'b00, 10, e);
    tick(2);
    chk("fwd_count", n_acr - a0, X4 ? 4 : 1);
    chk("fwd_no_dec", n_dec - d0, 0);
    chk("fwd_latency", last_acr - e, 7);
    a0 = n_acr; d0 = n_dec;
    put(2'b10, 10, e); put(2'b11, 10, e); put(2'b01, 10, e); put(2'b00, 10, e);
    tick(2);
    chk("rev_count", n_dec - d0, X4 ? 4 : 1);
    chk("rev_no_acr", n_acr - a0, 0);
    chk("rev_latency", last_dec - e, 7);
    a0 = n_acr; d0 = n_dec;
    put(2'b10, 3, e); put(2'b00, 12, e);
    put(2'b01, 3, e); put(2'b00, 12, e);
    chk("glitch3_pulses", n_acr + n_dec - a0 - d0, 0);
    chk("glitch3_estado", int'(bus.estado_ab), 0);
    put(2'b01, 4, e); put(2'b00, 3, e);
    chk("glitch4_estado", int'(bus.estado_ab), 1);
    tick(10);
    chk("glitch4_acr", n_acr - a0, X4 ? 1 : 0);
    chk("glitch4_dec", n_dec - d0, 1);
    a0 = n_acr; d0 = n_dec;
    put(2'b11, 12, e);
    chk("ilg_erro", int'(bus.erro), 1);
    chk("ilg_estado", int'(bus.estado_ab), 3);
    chk("ilg_no_pulse", n_acr + n_dec - a0 - d0, 0);
    bus.limpar_erro = 1'b1; tick(1); bus.limpar_erro = 1'b0;
    chk("clr_erro", int'(bus.erro), 0);
    put(2'b00, 6, e);
    bus.limpar_erro = 1'b1; tick(1); bus.limpar_erro = 1'b0;
    chk("set_wins", int'(bus.erro), 1);
    tick(1);
    chk("set_sticky", int'(bus.erro), 1);
    bus.limpar_erro = 1'b1; tick(1); bus.limpar_erro = 1'b0;
    chk("clr_erro2", int'(bus.erro), 0);
    #1 rst = 1'b1;
    {bus.canal_a, bus.canal_b} = 2'b11;
    tick(3);
    rst = 1'b0;
    a0 = n_acr; d0 = n_dec;
    tick(12);
    chk("init11_estado", int'(bus.estado_ab), 3);
    chk("init11_erro", int'(bus.erro), 0);
    chk("init11_no_pulse", n_acr + n_dec - a0 - d0, 0);
    put(2'b10, 10, e); put(2'b00, 10, e);
    bus.habilitar = 1'b0;
    a0 = n_acr; d0 = n_dec;
    put(2'b01, 10, e);
    chk("dis_no_pulse", n_acr + n_dec - a0 - d0, 0);
    chk("dis_estado", int'(bus.estado_ab), 1);
    bus.habilitar = 1'b1;
    a0 = n_acr;
    put(2'b11, 10, e);
    chk("reen_acr", n_acr - a0, X4 ? 1 : 0);
    a0 = n_acr; d0 = n_dec;
    put(2'b10, 5, e);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_acr", int'(bus.acrescer), 0);
    chk("rstmid_dec", int'(bus.decrecer), 0);
    chk("rstmid_erro", int'(bus.erro), 0);
    chk("rstmid_estado", int'(bus.estado_ab), 0);
    tick(2);
    rst = 1'b0;
    tick(15);
    chk("rstmid_no_pulse", n_acr + n_dec - a0 - d0, 0);
    chk("rstmid_estado_after", int'(bus.estado_ab), 2);
    chk("rstmid_erro_after", int'(bus.erro), 0);
    for (int i = 0; i < 300; i++) begin
      bus.habilitar = $urandom_range(0, 9) != 0;
      bus.limpar_erro = $urandom_range(0, 9) == 0;
      put(2'($urandom), $urandom_range(1, 8), e);
    end
    bus.limpar_erro = 1'b0;
    tick(12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
